myo_spi_frame_sequencer: RTL and testbench

//  Per-transaction SPI frame sequencer between the motor-control loop and the 16-bit spi_master core.
//  - On start: latches pwmRef and asserts ss_n. Streams FRAME_WORDS words (header, pwmRef, zero padding) through the

---
 rtl/myo_spi_pkg.sv | 28 ++
 rtl/myo_cycle_down_counter.sv | 27 ++
 rtl/myo_spi_frame_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_myo_spi_frame_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/myo_spi_pkg.sv
// Shared types and constants for the SPI frame sequencer: FSM encoding,
// reply slot indices and the default frame header.
package myo_spi_pkg;

  localparam int unsigned WORD_W      = 16;
  localparam int unsigned REPLY_SLOTS = 8;

  localparam logic [WORD_W-1:0] DEFAULT_HEADER_WORD = 16'h8000;

  localparam int unsigned SLOT_STATUS = 0;
  localparam int unsigned SLOT_POS_HI = 1;
  localparam int unsigned SLOT_POS_LO = 2;
  localparam int unsigned SLOT_VEL    = 3;
  localparam int unsigned SLOT_CUR    = 4;
  localparam int unsigned SLOT_DISP   = 5;
  localparam int unsigned SLOT_S1     = 6;
  localparam int unsigned SLOT_S2     = 7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_LOAD,
    ST_WAIT_RX,
    ST_GUARD,
    ST_DONE
  } state_e;

endpackage

// File: rtl/myo_cycle_down_counter.sv
// Loadable down counter with a zero flag; saturates at zero.
module myo_cycle_down_counter #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (dec_i && (count_q != '0)) begin
      count_q <= count_q - WIDTH'(1);
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/myo_spi_frame_sequencer.sv
// Per-transaction SPI frame sequencer in front of the 16-bit spi_master core.
// Optional per-word watchdog enabled by defining MYO_SPI_TIMEOUT_EN.
module myo_spi_frame_sequencer
  import myo_spi_pkg::*;
#(
  parameter int unsigned       FRAME_WORDS     = 8,
  parameter logic [WORD_W-1:0] HEADER_WORD     = DEFAULT_HEADER_WORD,
  parameter int unsigned       SS_SETUP_CYCLES = 2,
  parameter int unsigned       SS_GUARD_CYCLES = 4,
  parameter int unsigned       TIMEOUT_CYCLES  = 1000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] pwmRef,
  input  logic              write_ack,
  input  logic              data_read_valid,
  input  logic [WORD_W-1:0] data_read,
  output logic [WORD_W-1:0] Word,
  output logic              wren,
  output logic              ss_n,
  output logic              spi_done,
  output logic [WORD_W-1:0] status,
  output logic [31:0]       position,
  output logic [WORD_W-1:0] velocity,
  output logic [WORD_W-1:0] current,
  output logic [WORD_W-1:0] displacement,
  output logic [WORD_W-1:0] sensor1,
  output logic [WORD_W-1:0] sensor2,
  output logic              frame_error
);

  localparam int unsigned IDX_W    = $clog2(FRAME_WORDS);
  localparam bit          SETUP_EN = (SS_SETUP_CYCLES != 0);
  localparam bit          GUARD_EN = (SS_GUARD_CYCLES != 0);
  localparam int unsigned SETUP_LD = SETUP_EN ? SS_SETUP_CYCLES - 1 : 0;
  localparam int unsigned GUARD_LD = GUARD_EN ? SS_GUARD_CYCLES - 1 : 0;
  localparam int unsigned TMO_LD   = (TIMEOUT_CYCLES != 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam int unsigned MAX_A    = (SETUP_LD > GUARD_LD) ? SETUP_LD : GUARD_LD;
  localparam int unsigned CNT_MAX  = (MAX_A > TMO_LD) ? MAX_A : TMO_LD;
  localparam int unsigned CNT_W    = $clog2(CNT_MAX + 2);

  state_e            state_q;
  logic [IDX_W-1:0]  idx_q;
  logic [WORD_W-1:0] pwm_q;
  logic [WORD_W-1:0] word_q;
  logic              wren_q, ss_n_q, spi_done_q;
  logic [WORD_W-1:0] shadow_q [REPLY_SLOTS];
  logic [WORD_W-1:0] shadow_c [REPLY_SLOTS];

  logic              cap_c, last_c, timeout_c, abort_c, start_go_c;
  logic              enter_load_c, next_load_c, enter_guard_c, publish_c, publish_data_c;
  logic              cnt_load_c, cnt_dec_c, cnt_zero;
  logic [CNT_W-1:0]  cnt_val_c;

`ifdef MYO_SPI_TIMEOUT_EN
  logic frame_error_q, aborted_q;
  assign frame_error = frame_error_q;
`else
  assign frame_error = 1'b0;
`endif

  // MOSI word for a given frame index: header, latched reference, then padding.
  function automatic logic [WORD_W-1:0] frame_word(input logic [IDX_W-1:0] idx,
                                                  input logic [WORD_W-1:0] pwm);
    if (idx == IDX_W'(0)) return HEADER_WORD;
    else if (idx == IDX_W'(1)) return pwm;
    else return '0;
  endfunction

  always_comb begin
    cap_c      = ((state_q == ST_LOAD && write_ack) || state_q == ST_WAIT_RX) && data_read_valid;
    last_c     = cap_c && (idx_q == IDX_W'(FRAME_WORDS - 1));
    timeout_c  = 1'b0;
    abort_c    = 1'b0;
`ifdef MYO_SPI_TIMEOUT_EN
    timeout_c  = (state_q == ST_LOAD || state_q == ST_WAIT_RX) && cnt_zero && !cap_c;
    abort_c    = aborted_q || timeout_c;
`endif
    start_go_c     = (state_q == ST_IDLE) && start;
    next_load_c    = cap_c && !last_c;
    enter_load_c   = (start_go_c && !SETUP_EN) || (state_q == ST_SETUP && cnt_zero) || next_load_c;
    enter_guard_c  = last_c || timeout_c;
    publish_c      = (enter_guard_c && !GUARD_EN) || (state_q == ST_GUARD && cnt_zero);
    publish_data_c = publish_c && !abort_c;
    cnt_load_c     = start_go_c || enter_load_c || enter_guard_c;
    if (enter_guard_c)     cnt_val_c = CNT_W'(GUARD_LD);
    else if (enter_load_c) cnt_val_c = CNT_W'(TMO_LD);
    else                   cnt_val_c = CNT_W'(SETUP_LD);
    cnt_dec_c = !cnt_load_c && !cnt_zero;
  end

  // Shadow slots with the current capture folded in, so a zero-guard frame publishes its last reply.
  always_comb begin
    for (int unsigned i = 0; i < REPLY_SLOTS; i++) begin
      shadow_c[i] = (cap_c && idx_q == IDX_W'(i)) ? data_read : shadow_q[i];
    end
  end

  myo_cycle_down_counter #(.WIDTH(CNT_W)) u_cnt (
    .clock      (clock),
    .reset      (reset),
    .load_i     (cnt_load_c),
    .load_val_i (cnt_val_c),
    .dec_i      (cnt_dec_c),
    .zero_o     (cnt_zero)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      pwm_q        <= '0;
      word_q       <= '0;
      wren_q       <= 1'b0;
      ss_n_q       <= 1'b1;
      spi_done_q   <= 1'b1;
      shadow_q     <= '{default: '0};
      status       <= '0;
      position     <= '0;
      velocity     <= '0;
      current      <= '0;
      displacement <= '0;
      sensor1      <= '0;
      sensor2      <= '0;
`ifdef MYO_SPI_TIMEOUT_EN
      frame_error_q <= 1'b0;
      aborted_q     <= 1'b0;
`endif
    end else begin
      shadow_q <= shadow_c;
`ifdef MYO_SPI_TIMEOUT_EN
      frame_error_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            pwm_q      <= pwmRef;
            idx_q      <= '0;
            ss_n_q     <= 1'b0;
            spi_done_q <= 1'b0;
            state_q    <= ST_SETUP;
          end
        end
        ST_LOAD: begin
          if (write_ack) begin
            wren_q  <= 1'b0;
            state_q <= ST_WAIT_RX;
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: ;
      endcase

      // Later assignments take priority over the per-state defaults above.
      if (enter_load_c) begin
        state_q <= ST_LOAD;
        wren_q  <= 1'b1;
        word_q  <= start_go_c ? HEADER_WORD : frame_word(next_load_c ? idx_q + IDX_W'(1) : idx_q, pwm_q);
      end
      if (next_load_c) idx_q <= idx_q + IDX_W'(1);
      if (enter_guard_c) begin
        wren_q  <= 1'b0;
        state_q <= ST_GUARD;
      end
`ifdef MYO_SPI_TIMEOUT_EN
      if (timeout_c) begin
        frame_error_q <= 1'b1;
        aborted_q     <= 1'b1;
      end
      if (publish_c) aborted_q <= 1'b0;
`endif
      if (publish_c) begin
        state_q    <= ST_DONE;
        ss_n_q     <= 1'b1;
        spi_done_q <= 1'b1;
      end
      if (publish_data_c) begin
        status       <= shadow_c[SLOT_STATUS];
        position     <= {shadow_c[SLOT_POS_HI], shadow_c[SLOT_POS_LO]};
        velocity     <= shadow_c[SLOT_VEL];
        current      <= shadow_c[SLOT_CUR];
        displacement <= shadow_c[SLOT_DISP];
        sensor1      <= shadow_c[SLOT_S1];
        sensor2      <= shadow_c[SLOT_S2];
      end
    end
  end

  assign Word     = word_q;
  assign wren     = wren_q;
  assign ss_n     = ss_n_q;
  assign spi_done = spi_done_q;

endmodule

// File: tb/tb_myo_spi_frame_sequencer.sv
// Directed bench for myo_spi_frame_sequencer: a default-timing instance and a
// zero setup/guard instance share one spi_master model selected by sel_z.
module tb_myo_spi_frame_sequencer;

  localparam int W_TIME = 3;
  localparam int BUDGET = 400;
  localparam int LOW_EXP = 2 + 8 * (2 + W_TIME) + 4;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic        start, sel_z, write_ack, data_read_valid;
  logic [15:0] pwmRef, data_read;
  logic        start_a, start_z, ack_a, ack_z, drv_a, drv_z;

  logic [15:0] a_word, a_status, a_vel, a_cur, a_disp, a_s1, a_s2;
  logic [15:0] z_word, z_status, z_vel, z_cur, z_disp, z_s1, z_s2;
  logic [31:0] a_pos, z_pos;
  logic        a_wren, a_ss_n, a_done, a_ferr, z_wren, z_ss_n, z_done, z_ferr;

  logic [15:0] obs_word, obs_status, obs_vel, obs_cur, obs_disp, obs_s1, obs_s2;
  logic [31:0] obs_pos;
  logic        obs_wren, obs_ss_n, obs_done;

  assign start_a = start & ~sel_z;
  assign start_z = start & sel_z;
  assign ack_a   = write_ack & ~sel_z;
  assign ack_z   = write_ack & sel_z;
  assign drv_a   = data_read_valid & ~sel_z;
  assign drv_z   = data_read_valid & sel_z;

  assign obs_word   = sel_z ? z_word   : a_word;
  assign obs_wren   = sel_z ? z_wren   : a_wren;
  assign obs_ss_n   = sel_z ? z_ss_n   : a_ss_n;
  assign obs_done   = sel_z ? z_done   : a_done;
  assign obs_status = sel_z ? z_status : a_status;
  assign obs_pos    = sel_z ? z_pos    : a_pos;
  assign obs_vel    = sel_z ? z_vel    : a_vel;
  assign obs_cur    = sel_z ? z_cur    : a_cur;
  assign obs_disp   = sel_z ? z_disp   : a_disp;
  assign obs_s1     = sel_z ? z_s1     : a_s1;
  assign obs_s2     = sel_z ? z_s2     : a_s2;

  myo_spi_frame_sequencer #(
    .FRAME_WORDS(8), .HEADER_WORD(16'h8000), .SS_SETUP_CYCLES(2),
    .SS_GUARD_CYCLES(4), .TIMEOUT_CYCLES(50)
  ) dut (
    .clock(clock), .reset(reset), .start(start_a), .pwmRef(pwmRef),
    .write_ack(ack_a), .data_read_valid(drv_a), .data_read(data_read),
    .Word(a_word), .wren(a_wren), .ss_n(a_ss_n), .spi_done(a_done),
    .status(a_status), .position(a_pos), .velocity(a_vel), .current(a_cur),
    .displacement(a_disp), .sensor1(a_s1), .sensor2(a_s2), .frame_error(a_ferr)
  );

  myo_spi_frame_sequencer #(
    .FRAME_WORDS(8), .HEADER_WORD(16'h8000), .SS_SETUP_CYCLES(0),
    .SS_GUARD_CYCLES(0), .TIMEOUT_CYCLES(50)
  ) dut_z (
    .clock(clock), .reset(reset), .start(start_z), .pwmRef(pwmRef),
    .write_ack(ack_z), .data_read_valid(drv_z), .data_read(data_read),
    .Word(z_word), .wren(z_wren), .ss_n(z_ss_n), .spi_done(z_done),
    .status(z_status), .position(z_pos), .velocity(z_vel), .current(z_cur),
    .displacement(z_disp), .sensor1(z_s1), .sensor2(z_s2), .frame_error(z_ferr)
  );

  // spi_master model: acks wren at once, replies W_TIME cycles later (or in the same cycle when coincident)
  logic [15:0] reply [8];
  logic [15:0] mosi  [16];
  int bfm_k = 0, bfm_cnt = 0, bfm_drop = -1;
  bit bfm_rx = 1'b0, bfm_coinc = 1'b0, bfm_clr = 1'b0;

  initial begin
    write_ack = 1'b0; data_read_valid = 1'b0; data_read = '0;
    forever begin
      @(posedge clock); #1;
      write_ack = 1'b0; data_read_valid = 1'b0;
      if (reset || bfm_clr) begin
        bfm_k = 0; bfm_rx = 1'b0;
      end else if (bfm_rx) begin
        if (bfm_cnt > 0) bfm_cnt--;
        else if (bfm_k != bfm_drop) begin
          data_read_valid = 1'b1; data_read = reply[bfm_k % 8]; bfm_k++; bfm_rx = 1'b0;
        end
      end else if (obs_wren) begin
        mosi[bfm_k % 16] = obs_word;
        write_ack = 1'b1;
        if (bfm_coinc) begin
          data_read_valid = 1'b1; data_read = reply[bfm_k % 8]; bfm_k++;
        end else begin
          bfm_rx = 1'b1; bfm_cnt = W_TIME;
        end
      end
    end
  end

  int ss_falls = 0, ss_rises = 0, err_pulses = 0;
  logic prev_ss = 1'b1;
  always @(negedge clock) begin
    if (prev_ss && !a_ss_n) ss_falls++;
    if (!prev_ss && a_ss_n) ss_rises++;
    prev_ss = a_ss_n;
    if (a_ferr || z_ferr) err_pulses++;
  end

  int checks = 0, failures = 0;
  int lowc;
  bit to;
  logic [31:0] pos_prev;

  task automatic bfm_clear();
    @(negedge clock); bfm_clr = 1'b1;
    @(negedge clock); bfm_clr = 1'b0;
  endtask

  task automatic set_replies(input logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7);
    reply[0] = r0; reply[1] = r1; reply[2] = r2; reply[3] = r3;
    reply[4] = r4; reply[5] = r5; reply[6] = r6; reply[7] = r7;
  endtask

  // Start one frame and wait for spi_done; optionally change pwmRef and pulse start mid-frame.
  task automatic run_frame(input logic [15:0] pwm, input logic [15:0] pwm_after, input bit busy);
    @(negedge clock); pwmRef = pwm; start = 1'b1;
    @(negedge clock); start = 1'b0; pwmRef = pwm_after;
    lowc = 0; to = 1'b1; pos_prev = obs_pos;
    for (int i = 0; i < BUDGET; i++) begin
      if (obs_done) begin to = 1'b0; break; end
      lowc++; pos_prev = obs_pos;
      @(negedge clock);
      start = busy && (lowc == 10 || lowc == 25);
    end
    start = 1'b0;
    checks++;
    if (to !== 1'b0) begin failures++; $display("FAIL frame_timeout spi_done never rose within %0d cycles", BUDGET); end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    checks++; if (a_ss_n !== 1'b1) begin failures++; $display("FAIL reset_ss_n got=%b exp=1", a_ss_n); end
    checks++; if (a_done !== 1'b1) begin failures++; $display("FAIL reset_spi_done got=%b exp=1", a_done); end
    checks++; if (a_wren !== 1'b0) begin failures++; $display("FAIL reset_wren got=%b exp=0", a_wren); end
    checks++; if (a_word !== 16'h0) begin failures++; $display("FAIL reset_word got=%h exp=0000", a_word); end
    checks++; if (a_pos !== 32'h0) begin failures++; $display("FAIL reset_position got=%h exp=0", a_pos); end
    checks++; if (a_ferr !== 1'b0) begin failures++; $display("FAIL reset_frame_error got=%b exp=0", a_ferr); end
    reset = 1'b0;
  endtask

  task automatic test_basic_frame();
    logic [15:0] exp_mosi [8];
    exp_mosi = '{16'h8000, 16'h0123, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    set_replies(16'h0011, 16'h0001, 16'h8000, 16'hFFF6, 16'h0064, 16'h0200, 16'h0007, 16'hFFFF);
    bfm_clear();
    run_frame(16'h0123, 16'h0123, 1'b0);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (mosi[i] !== exp_mosi[i]) begin failures++; $display("FAIL basic_mosi[%0d] got=%h exp=%h", i, mosi[i], exp_mosi[i]); end
    end
    checks++; if (lowc != LOW_EXP) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=%0d", lowc, LOW_EXP); end
    checks++; if (a_status !== 16'h0011) begin failures++; $display("FAIL basic_status got=%h exp=0011", a_status); end
    checks++; if (a_pos !== 32'h00018000) begin failures++; $display("FAIL basic_position got=%h exp=00018000", a_pos); end
    checks++; if (a_vel !== 16'hFFF6) begin failures++; $display("FAIL basic_velocity got=%h exp=fff6", a_vel); end
    checks++; if (a_cur !== 16'h0064) begin failures++; $display("FAIL basic_current got=%h exp=0064", a_cur); end
    checks++; if (a_disp !== 16'h0200) begin failures++; $display("FAIL basic_displacement got=%h exp=0200", a_disp); end
    checks++; if (a_s1 !== 16'h0007 || a_s2 !== 16'hFFFF) begin failures++; $display("FAIL basic_sensors got=%h,%h exp=0007,ffff", a_s1, a_s2); end
    checks++; if (pos_prev !== 32'h0) begin failures++; $display("FAIL basic_publish_edge position before done got=%h exp=0", pos_prev); end
    checks++; if (a_ss_n !== 1'b1) begin failures++; $display("FAIL basic_ss_n_after got=%b exp=1", a_ss_n); end
  endtask

  task automatic test_pwm_latch();
    bfm_clear();
    run_frame(16'h0AAA, 16'h5555, 1'b0);
    checks++; if (mosi[0] !== 16'h8000) begin failures++; $display("FAIL latch_header got=%h exp=8000", mosi[0]); end
    checks++; if (mosi[1] !== 16'h0AAA) begin failures++; $display("FAIL latch_pwm got=%h exp=0aaa", mosi[1]); end
  endtask

  task automatic test_busy_start();
    int f0, r0;
    bfm_clear();
    #1; f0 = ss_falls; r0 = ss_rises;
    run_frame(16'h0042, 16'h0042, 1'b1);
    repeat (10) @(negedge clock);
    #1;
    checks++; if (ss_falls - f0 != 1) begin failures++; $display("FAIL busy_ss_falls got=%0d exp=1", ss_falls - f0); end
    checks++; if (ss_rises - r0 != 1) begin failures++; $display("FAIL busy_ss_rises got=%0d exp=1", ss_rises - r0); end
    checks++; if (lowc != LOW_EXP) begin failures++; $display("FAIL busy_cycles got=%0d exp=%0d", lowc, LOW_EXP); end
    checks++; if (a_ss_n !== 1'b1 || a_done !== 1'b1) begin failures++; $display("FAIL busy_idle_after ss_n=%b done=%b exp=1,1", a_ss_n, a_done); end
  endtask

  task automatic test_reset_mid();
    bit hit = 1'b0;
    bfm_clear();
    @(negedge clock); pwmRef = 16'h0777; start = 1'b1;
    @(negedge clock); start = 1'b0;
    for (int i = 0; i < BUDGET; i++) begin
      if (bfm_k == 3 && a_wren) begin hit = 1'b1; break; end
      @(negedge clock);
    end
    checks++; if (!hit) begin failures++; $display("FAIL rstmid_reach_word3 got=%0d exp=3", bfm_k); end
    reset = 1'b1;
    @(negedge clock);
    checks++; if (a_ss_n !== 1'b1 || a_done !== 1'b1) begin failures++; $display("FAIL rstmid_ctrl ss_n=%b done=%b exp=1,1", a_ss_n, a_done); end
    checks++; if (a_wren !== 1'b0) begin failures++; $display("FAIL rstmid_wren got=%b exp=0", a_wren); end
    checks++; if (a_pos !== 32'h0 || a_status !== 16'h0 || a_s2 !== 16'h0) begin failures++; $display("FAIL rstmid_outputs pos=%h status=%h s2=%h exp=0", a_pos, a_status, a_s2); end
    @(negedge clock); reset = 1'b0;
    set_replies(16'h00A5, 16'h1234, 16'h5678, 16'h0010, 16'hFF00, 16'h0003, 16'h8000, 16'h0001);
    bfm_clear();
    run_frame(16'h0777, 16'h0777, 1'b0);
    checks++; if (mosi[1] !== 16'h0777) begin failures++; $display("FAIL rstmid_pwm got=%h exp=0777", mosi[1]); end
    checks++; if (a_pos !== 32'h12345678) begin failures++; $display("FAIL rstmid_position got=%h exp=12345678", a_pos); end
    checks++; if (a_status !== 16'h00A5 || a_vel !== 16'h0010) begin failures++; $display("FAIL rstmid_status_vel got=%h,%h exp=00a5,0010", a_status, a_vel); end
    checks++; if (a_s1 !== 16'h8000 || a_s2 !== 16'h0001) begin failures++; $display("FAIL rstmid_sensors got=%h,%h exp=8000,0001", a_s1, a_s2); end
  endtask

`ifdef MYO_SPI_TIMEOUT_EN
  task automatic test_timeout();
    int e0;
    set_replies(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888);
    bfm_drop = 4;
    bfm_clear();
    #1; e0 = err_pulses;
    run_frame(16'h0999, 16'h0999, 1'b0);
    #1;
    checks++; if (err_pulses - e0 != 1) begin failures++; $display("FAIL timeout_pulses got=%0d exp=1", err_pulses - e0); end
    checks++; if (a_pos !== 32'h12345678 || a_status !== 16'h00A5) begin failures++; $display("FAIL timeout_hold pos=%h status=%h exp=12345678,00a5", a_pos, a_status); end
    checks++; if (a_ss_n !== 1'b1 || a_wren !== 1'b0) begin failures++; $display("FAIL timeout_ctrl ss_n=%b wren=%b exp=1,0", a_ss_n, a_wren); end
    bfm_drop = -1;
    bfm_clear();
  endtask
`else
  task automatic test_no_frame_error();
    #1;
    checks++; if (err_pulses != 0) begin failures++; $display("FAIL no_frame_error got=%0d exp=0", err_pulses); end
  endtask
`endif

  task automatic test_zero_setup_guard();
    sel_z = 1'b1; bfm_coinc = 1'b1;
    set_replies(16'h0022, 16'hABCD, 16'hEF01, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 16'h0006);
    bfm_clear();
    run_frame(16'h0321, 16'h0321, 1'b0);
    checks++; if (mosi[0] !== 16'h8000 || mosi[1] !== 16'h0321 || mosi[7] !== 16'h0) begin failures++; $display("FAIL zero_mosi got=%h,%h,%h exp=8000,0321,0000", mosi[0], mosi[1], mosi[7]); end
    checks++; if (z_status !== 16'h0022) begin failures++; $display("FAIL zero_status got=%h exp=0022", z_status); end
    checks++; if (z_pos !== 32'hABCDEF01) begin failures++; $display("FAIL zero_position got=%h exp=abcdef01", z_pos); end
    checks++; if (z_vel !== 16'h0002 || z_cur !== 16'h0003 || z_disp !== 16'h0004) begin failures++; $display("FAIL zero_vcd got=%h,%h,%h exp=0002,0003,0004", z_vel, z_cur, z_disp); end
    checks++; if (z_s1 !== 16'h0005 || z_s2 !== 16'h0006) begin failures++; $display("FAIL zero_sensors got=%h,%h exp=0005,0006", z_s1, z_s2); end
    checks++; if (pos_prev !== 32'h0 || z_ss_n !== 1'b1) begin failures++; $display("FAIL zero_publish_edge prev=%h ss_n=%b exp=0,1", pos_prev, z_ss_n); end
    sel_z = 1'b0; bfm_coinc = 1'b0;
  endtask

  initial begin
    start = 1'b0; sel_z = 1'b0; pwmRef = '0;
    test_reset();
    test_basic_frame();
    test_pwm_latch();
    test_busy_start();
    test_reset_mid();
`ifdef MYO_SPI_TIMEOUT_EN
    test_timeout();
`else
    test_no_frame_error();
`endif
    test_zero_setup_guard();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
